// File: rtl/prog_loader_pkg.sv
// prog_loader_pkg: shared state encoding, size defaults and header helpers for the program loader
package prog_loader_pkg;

    localparam int ADDR_W_DEF = 10;
    localparam int DEPTH_DEF  = 1 << ADDR_W_DEF;
    localparam int LEN_BYTES  = 2;
    localparam int WORD_BYTES = 4;

    typedef enum logic [2:0] {
        S_IDLE,
        S_LEN_HI,
        S_LEN_LO,
        S_DATA,
        S_WRITE,
        S_FINISH,
        S_ERR
    } state_t;

    typedef enum logic [1:0] {
        HDR_EMPTY,
        HDR_TOO_LONG,
        HDR_OK
    } hdr_t;

    // An empty program finishes at once; anything longer than the memory is rejected.
    function automatic hdr_t classify_len(input logic [8*LEN_BYTES-1:0] len, input int depth);
        if (len == '0) return HDR_EMPTY;
        if (int'(len) > depth) return HDR_TOO_LONG;
        return HDR_OK;
    endfunction

endpackage

// File: rtl/prog_loader_if.sv
// prog_loader_if: byte stream in, instruction-memory write port and status out
interface prog_loader_if import prog_loader_pkg::*; #(
    parameter int ADDR_W = ADDR_W_DEF
);

    logic              start;
    logic [7:0]        byte_in;
    logic              byte_valid;
    logic              byte_ready;
    logic              mem_we;
    logic [ADDR_W-1:0] mem_addr;
    logic [31:0]       mem_din;
    logic              cpu_hold;
    logic              done;
    logic              error;

    modport master (
        output start, byte_in, byte_valid,
        input  byte_ready, mem_we, mem_addr, mem_din, cpu_hold, done, error
    );

    modport slave (
        input  start, byte_in, byte_valid,
        output byte_ready, mem_we, mem_addr, mem_din, cpu_hold, done, error
    );

endinterface

// File: rtl/prog_loader_byte_assembler.sv
// byte_assembler: packs a big-endian byte stream into 32-bit words
module byte_assembler import prog_loader_pkg::*; (
    input  logic        clk,
    input  logic        rst,
    input  logic        clr_i,
    input  logic        push_i,
    input  logic [7:0]  byte_i,
    output logic [31:0] word_o,
    output logic        word_valid_o
);

    logic [31:0] shift_q;
    logic [1:0]  cnt_q;

    // Shift each accepted byte in at the bottom so the first byte ends up in bits 31:24
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            shift_q <= '0;
            cnt_q   <= '0;
        end else if (clr_i) begin
            shift_q <= '0;
            cnt_q   <= '0;
        end else if (push_i) begin
            shift_q <= {shift_q[23:0], byte_i};
            cnt_q   <= cnt_q + 2'd1;
        end
    end

    assign word_o       = shift_q;
    assign word_valid_o = push_i && cnt_q == 2'(WORD_BYTES - 1);

endmodule

// File: rtl/prog_loader.sv
// prog_loader: receives a length-prefixed program stream and writes it into instruction memory
module prog_loader import prog_loader_pkg::*; #(
    parameter int ADDR_W = ADDR_W_DEF,
    parameter int DEPTH  = DEPTH_DEF
) (
    input  logic         clk,
    input  logic         rst,
    prog_loader_if.slave bus
);

    state_t            state_q;
    logic [7:0]        len_hi_q;
    logic [15:0]       len_q;
    logic [15:0]       len_d;
    logic [ADDR_W:0]   word_cnt_q;
    logic              byte_ready_q;
    logic              mem_we_q;
    logic [ADDR_W-1:0] mem_addr_q;
    logic              cpu_hold_q;
    logic              done_q;
    logic              error_q;
    logic              xfer;
    logic              word_valid;
    logic              last_word;
    logic [31:0]       word;

    assign xfer      = bus.byte_valid && byte_ready_q;
    assign len_d     = {len_hi_q, bus.byte_in};
    assign last_word = 17'(word_cnt_q) + 17'd1 == {1'b0, len_q};

    byte_assembler u_asm (
        .clk          (clk),
        .rst          (rst),
        .clr_i        (state_q == S_IDLE && bus.start),
        .push_i       (xfer && state_q == S_DATA),
        .byte_i       (bus.byte_in),
        .word_o       (word),
        .word_valid_o (word_valid)
    );

    // Session sequencer; every output is a register so the memory port and hold are glitch-free
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= S_IDLE;
            len_hi_q     <= '0;
            len_q        <= '0;
            word_cnt_q   <= '0;
            byte_ready_q <= 1'b0;
            mem_we_q     <= 1'b0;
            mem_addr_q   <= '0;
            cpu_hold_q   <= 1'b0;
            done_q       <= 1'b0;
            error_q      <= 1'b0;
        end else begin
            case (state_q)
                S_IDLE: if (bus.start) begin
                    state_q      <= S_LEN_HI;
                    byte_ready_q <= 1'b1;
                    cpu_hold_q   <= 1'b1;
                    done_q       <= 1'b0;
                    error_q      <= 1'b0;
                    word_cnt_q   <= '0;
                end
                S_LEN_HI: if (xfer) begin
                    len_hi_q <= bus.byte_in;
                    state_q  <= S_LEN_LO;
                end
                S_LEN_LO: if (xfer) begin
                    len_q <= len_d;
                    case (classify_len(len_d, DEPTH))
                        HDR_EMPTY: begin
                            state_q      <= S_FINISH;
                            byte_ready_q <= 1'b0;
                        end
                        HDR_TOO_LONG: begin
                            state_q      <= S_ERR;
                            byte_ready_q <= 1'b0;
                        end
                        default: state_q <= S_DATA;
                    endcase
                end
                S_DATA: if (word_valid) begin
                    state_q      <= S_WRITE;
                    byte_ready_q <= 1'b0;
                    mem_we_q     <= 1'b1;
                    mem_addr_q   <= word_cnt_q[ADDR_W-1:0];
                end
                S_WRITE: begin
                    mem_we_q   <= 1'b0;
                    word_cnt_q <= word_cnt_q + 1'b1;
                    if (last_word) begin
                        state_q <= S_FINISH;
                    end else begin
                        state_q      <= S_DATA;
                        byte_ready_q <= 1'b1;
                    end
                end
                S_FINISH: begin
                    done_q     <= 1'b1;
                    cpu_hold_q <= 1'b0;
                    state_q    <= S_IDLE;
                end
                S_ERR: begin
                    error_q    <= 1'b1;
                    cpu_hold_q <= 1'b0;
                    state_q    <= S_IDLE;
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

    assign bus.byte_ready = byte_ready_q;
    assign bus.mem_we     = mem_we_q;
    assign bus.mem_addr   = mem_addr_q;
    assign bus.mem_din    = word;
    assign bus.cpu_hold   = cpu_hold_q;
    assign bus.done       = done_q;
    assign bus.error      = error_q;

endmodule

// File: tb/tb_prog_loader.sv
// tb_prog_loader: directed scenarios for the program loader with a write-log memory model
module tb_prog_loader;

    localparam int AW = 10;

    logic clk = 1'b0;
    logic rst = 1'b1;

    prog_loader_if #(.ADDR_W(AW)) bus ();

    prog_loader #(.ADDR_W(AW), .DEPTH(1024)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    int checks   = 0;
    int failures = 0;
    int cyc      = 0;
    int wr_cnt   = 0;

    logic [AW-1:0] wa [2048];
    logic [31:0]   wd [2048];

    // Free-running edge count for latency checks
    always @(posedge clk) cyc <= cyc + 1;

    // Log every memory write strobe seen mid-cycle
    always @(negedge clk) begin
        if (bus.mem_we === 1'b1 && wr_cnt < 2048) begin
            wa[wr_cnt] = bus.mem_addr;
            wd[wr_cnt] = bus.mem_din;
            wr_cnt     = wr_cnt + 1;
        end
    end

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic pulse_start();
        bus.start = 1'b1;
        @(negedge clk);
        bus.start = 1'b0;
    endtask

    task automatic send_byte(input logic [7:0] b);
        int t;
        t = 0;
        bus.byte_in    = b;
        bus.byte_valid = 1'b1;
        while (bus.byte_ready !== 1'b1 && t < 20) begin
            @(negedge clk);
            t++;
        end
        checks++;
        if (t >= 20) begin
            failures++;
            $display("FAIL send_byte_timeout byte=%02h byte_ready=%b required=1", b, bus.byte_ready);
        end
        @(negedge clk);
        bus.byte_valid = 1'b0;
    endtask

    task automatic send_word(input logic [31:0] w);
        send_byte(w[31:24]);
        send_byte(w[23:16]);
        send_byte(w[15:8]);
        send_byte(w[7:0]);
    endtask

    task automatic wait_idle(output int n);
        n = 0;
        while (bus.cpu_hold !== 1'b0 && n < 50) begin
            @(negedge clk);
            n++;
        end
        checks++;
        if (n >= 50) begin
            failures++;
            $display("FAIL wait_idle_timeout cpu_hold=%b required=0", bus.cpu_hold);
        end
    endtask

    task automatic test_reset();
        logic [AW+38:0] outs;
        outs = {bus.byte_ready, bus.mem_we, bus.mem_addr, bus.mem_din, bus.cpu_hold, bus.done, bus.error};
        checks++;
        if (outs !== '0) begin
            failures++;
            $display("FAIL reset_outputs got=%h required=0", outs);
        end
        rst = 1'b0;
        bus.byte_valid = 1'b1;
        bus.byte_in    = 8'hAA;
        tick(3);
        bus.byte_valid = 1'b0;
        checks++;
        if (bus.byte_ready !== 1'b0 || bus.cpu_hold !== 1'b0 || wr_cnt !== 0) begin
            failures++;
            $display("FAIL idle_quiet byte_ready=%b cpu_hold=%b writes=%0d required 0/0/0", bus.byte_ready, bus.cpu_hold, wr_cnt);
        end
    endtask

    task automatic test_basic();
        int base, c0, n;
        base = wr_cnt;
        c0   = cyc;
        pulse_start();
        checks++;
        if (bus.cpu_hold !== 1'b1 || bus.byte_ready !== 1'b1) begin
            failures++;
            $display("FAIL basic_hold_on cpu_hold=%b byte_ready=%b required 1/1", bus.cpu_hold, bus.byte_ready);
        end
        send_byte(8'h00);
        send_byte(8'h02);
        send_word(32'h8C010004);
        send_word(32'h00221820);
        wait_idle(n);
        checks++;
        if (wr_cnt - base !== 2) begin
            failures++;
            $display("FAIL basic_write_count got=%0d required=2", wr_cnt - base);
        end
        checks++;
        if (wa[base] !== 10'd0 || wd[base] !== 32'h8C010004) begin
            failures++;
            $display("FAIL basic_word0 addr=%0d data=%h required addr=0 data=8c010004", wa[base], wd[base]);
        end
        checks++;
        if (wa[base+1] !== 10'd1 || wd[base+1] !== 32'h00221820) begin
            failures++;
            $display("FAIL basic_word1 addr=%0d data=%h required addr=1 data=00221820", wa[base+1], wd[base+1]);
        end
        checks++;
        if (bus.done !== 1'b1 || bus.error !== 1'b0 || bus.cpu_hold !== 1'b0) begin
            failures++;
            $display("FAIL basic_status done=%b error=%b cpu_hold=%b required 1/0/0", bus.done, bus.error, bus.cpu_hold);
        end
        checks++;
        if (cyc - c0 !== 14) begin
            failures++;
            $display("FAIL basic_latency cycles=%0d required=14", cyc - c0);
        end
    endtask

    task automatic test_zero_len();
        int base, n;
        base = wr_cnt;
        pulse_start();
        checks++;
        if (bus.done !== 1'b0) begin
            failures++;
            $display("FAIL zero_done_cleared done=%b required=0", bus.done);
        end
        send_byte(8'h00);
        send_byte(8'h00);
        bus.start = 1'b1;
        n = 0;
        while (bus.done !== 1'b1 && n < 3) begin
            @(negedge clk);
            bus.start = 1'b0;
            n++;
        end
        bus.start = 1'b0;
        checks++;
        if (bus.done !== 1'b1 || bus.error !== 1'b0) begin
            failures++;
            $display("FAIL zero_status done=%b error=%b required 1/0", bus.done, bus.error);
        end
        tick(1);
        checks++;
        if (bus.cpu_hold !== 1'b0 || bus.byte_ready !== 1'b0 || wr_cnt - base !== 0) begin
            failures++;
            $display("FAIL zero_no_restart cpu_hold=%b byte_ready=%b writes=%0d required 0/0/0", bus.cpu_hold, bus.byte_ready, wr_cnt - base);
        end
    endtask

    task automatic test_too_long();
        int base, n;
        base = wr_cnt;
        pulse_start();
        send_byte(8'h04);
        send_byte(8'h01);
        wait_idle(n);
        checks++;
        if (bus.error !== 1'b1 || bus.done !== 1'b0) begin
            failures++;
            $display("FAIL long_status error=%b done=%b required 1/0", bus.error, bus.done);
        end
        bus.byte_valid = 1'b1;
        bus.byte_in    = 8'h55;
        tick(3);
        bus.byte_valid = 1'b0;
        checks++;
        if (bus.byte_ready !== 1'b0 || wr_cnt - base !== 0 || bus.cpu_hold !== 1'b0) begin
            failures++;
            $display("FAIL long_quiet byte_ready=%b writes=%0d cpu_hold=%b required 0/0/0", bus.byte_ready, wr_cnt - base, bus.cpu_hold);
        end
    endtask

    task automatic test_gaps();
        int base, n;
        logic [7:0] bytes [4];
        bytes[0] = 8'hDE;
        bytes[1] = 8'hAD;
        bytes[2] = 8'hBE;
        bytes[3] = 8'hEF;
        base = wr_cnt;
        pulse_start();
        send_byte(8'h00);
        tick(1);
        send_byte(8'h01);
        for (int i = 0; i < 4; i++) begin
            send_byte(bytes[i]);
            if (i == 1) pulse_start();
            else tick(1);
        end
        wait_idle(n);
        checks++;
        if (wr_cnt - base !== 1 || wa[base] !== 10'd0 || wd[base] !== 32'hDEADBEEF) begin
            failures++;
            $display("FAIL gaps_word writes=%0d addr=%0d data=%h required 1/0/deadbeef", wr_cnt - base, wa[base], wd[base]);
        end
        checks++;
        if (bus.done !== 1'b1 || bus.error !== 1'b0) begin
            failures++;
            $display("FAIL gaps_status done=%b error=%b required 1/0", bus.done, bus.error);
        end
    endtask

    task automatic test_reset_mid();
        int base, n;
        logic [AW+38:0] outs;
        base = wr_cnt;
        pulse_start();
        send_byte(8'h00);
        send_byte(8'h03);
        send_word(32'h11223344);
        send_byte(8'h55);
        send_byte(8'h66);
        #2;
        rst = 1'b1;
        #1;
        outs = {bus.byte_ready, bus.mem_we, bus.mem_addr, bus.mem_din, bus.cpu_hold, bus.done, bus.error};
        checks++;
        if (outs !== '0) begin
            failures++;
            $display("FAIL async_reset_outputs got=%h required=0", outs);
        end
        @(negedge clk);
        rst = 1'b0;
        tick(3);
        checks++;
        if (wr_cnt - base !== 1 || wa[base] !== 10'd0 || wd[base] !== 32'h11223344) begin
            failures++;
            $display("FAIL reset_partial writes=%0d addr=%0d data=%h required 1/0/11223344", wr_cnt - base, wa[base], wd[base]);
        end
        pulse_start();
        send_byte(8'h00);
        send_byte(8'h01);
        send_word(32'hA1B2C3D4);
        wait_idle(n);
        checks++;
        if (wr_cnt - base !== 2 || wa[base+1] !== 10'd0 || wd[base+1] !== 32'hA1B2C3D4 || bus.done !== 1'b1) begin
            failures++;
            $display("FAIL reset_reload writes=%0d addr=%0d data=%h done=%b required 2/0/a1b2c3d4/1", wr_cnt - base, wa[base+1], wd[base+1], bus.done);
        end
    endtask

    task automatic test_max();
        int base, n, bad;
        base = wr_cnt;
        pulse_start();
        send_byte(8'h04);
        send_byte(8'h00);
        for (int w = 0; w < 1024; w++) send_word(32'hC0DE0000 | 32'(w));
        wait_idle(n);
        checks++;
        if (wr_cnt - base !== 1024) begin
            failures++;
            $display("FAIL max_write_count got=%0d required=1024", wr_cnt - base);
        end
        checks++;
        if (wa[base+1023] !== 10'd1023 || wd[base+1023] !== 32'hC0DE03FF) begin
            failures++;
            $display("FAIL max_last addr=%0d data=%h required 1023/c0de03ff", wa[base+1023], wd[base+1023]);
        end
        bad = 0;
        for (int i = 0; i < 1024; i++)
            if (wa[base+i] !== 10'(i) || wd[base+i] !== (32'hC0DE0000 | 32'(i))) bad++;
        checks++;
        if (bad !== 0) begin
            failures++;
            $display("FAIL max_contents bad_words=%0d required=0", bad);
        end
        checks++;
        if (bus.done !== 1'b1 || bus.error !== 1'b0) begin
            failures++;
            $display("FAIL max_status done=%b error=%b required 1/0", bus.done, bus.error);
        end
    endtask

    initial begin
        bus.start      = 1'b0;
        bus.byte_in    = 8'h00;
        bus.byte_valid = 1'b0;
        tick(2);
        test_reset();
        test_basic();
        test_zero_len();
        test_too_long();
        test_gaps();
        test_reset_mid();
        test_max();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
